sp_mem_ctrl: RTL and testbench
==============================

# sp_mem_ctrl

Data-side memory controller that shares read port 1 and the single write port of the 2R/1W 32-bit memory model between two requesters: requester 0 is the core LSU and requester 1 is the debug/program loader. Sub-word stores (byte/half) are turned into read-modify-write sequences, because the memory only writes whole aligned words. Read port 0 (instruction fetch) does not pass through this block.

## Interface
- No parameters; widths come from `sp_pkg::ADDR_WIDTH` and `sp_pkg::DATA_WIDTH` (32).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `arst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in [1:0]: request valid, one bit per requester.
- `req_ready_o` out [1:0]: request accepted; handshake completes when valid & ready.
- `req_we_i` in [1:0]: 1 = store, 0 = load.
- `req_addr_i` in [1:0][ADDR_WIDTH-1:0]: byte address.
- `req_size_i` in [1:0][1:0]: `mem_size_t` (00 byte, 01 half, 10 word, 11 illegal).
- `req_wdata_i` in [1:0][DATA_WIDTH-1:0]: store data, right-aligned.
- `rsp_valid_o` out [1:0]: one-cycle response pulse to the granted requester; no backpressure.
- `rsp_err_o` out 1: error flag, qualified by `rsp_valid_o`.
- `rsp_rdata_o` out DATA_WIDTH: load data, right-aligned and zero-extended.
- `mem_raddr_o` out ADDR_WIDTH: drives read port 1 address; always word-aligned.
- `mem_rdata_i` in DATA_WIDTH: read port 1 data, combinational from address.
- `mem_we_o`, `mem_waddr_o`, `mem_wdata_o` out 1/ADDR_WIDTH/DATA_WIDTH: drive the write port.

## Operation
- FSM states: IDLE, RD, WR, RSP.
- **IDLE**
  - Round-robin grant among valid requesters; `req_ready_o` asserted only for the granted bit.
  - On handshake, latch requester id, we, addr, size and wdata.
  - Next state:
    - Error: RSP.
    - Load: RD.
    - Word store: WR.
    - Sub-word store: RD.
- **Error check**
  - Size 11 is an error.
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]≠0 is an error.
  - An error causes no memory access and no write.
- **RD**
  - `mem_raddr_o` = {addr[ADDR_WIDTH-1:2],2'b0}.
  - Capture `mem_rdata_i` into the word register.
  - Load goes to RSP; sub-word store goes to WR.
- **WR**
  - `mem_we_o`=1 for exactly one cycle.
  - `mem_waddr_o` = aligned address.
  - `mem_wdata_o`:
    - Word store: wdata.
    - Byte store: captured word with lane addr[1:0] replaced by wdata[7:0].
    - Half store: captured word with lanes {addr[1],0} and {addr[1],1} replaced by wdata[15:0].
  - Next state: RSP.
- **RSP**
  - `rsp_valid_o[id]`=1.
  - `rsp_err_o` = latched error.
  - `rsp_rdata_o`:
    - Load: lane-extracted, zero-extended.
    - Store or error: 0.
  - Next state: IDLE.
- **Arbitration**
  - The last-grant pointer resets to 1, so requester 0 wins the first contention.
  - Whichever requester is not last-granted wins a tie.
  - The pointer updates only on handshake.
- **Reset**
  - All outputs are 0 while `arst_ni`=0.
  - State returns to IDLE; latched request is cleared.
  - An in-flight RMW is abandoned; `mem_we_o` deasserts immediately, so no partial write occurs.

## Timing
- Handshake at cycle T; responses:
  - Error: T+1.
  - Load: T+2.
  - Word store: write at T+1, response T+2.
  - Sub-word store: read T+1, write T+2, response T+3.
- `req_ready_o` is combinational from state and `req_valid_i`.
- One transaction is outstanding at a time.
- The next handshake can occur in the cycle after RSP, i.e. IDLE.
- `mem_we_o` is a function of registered state only (glitch-free w.r.t. inputs).
- A write becomes visible to read port 1 from the cycle after WR.
- A load that follows a store to the same word returns the new data.

## Structure
- `sp_pkg` holds:
  - `typedef enum logic [1:0] mem_size_t` (MEM_BYTE, MEM_HALF, MEM_WORD, MEM_ILLEGAL).
  - `typedef enum` of the FSM states.
- Sub-module `sp_rr_arbiter`: 2-input round-robin arbiter with req/gr/update inputs, reusable by the fetch side later.
- Lane extraction and merging are local combinational logic.

## Test plan
- Req0 word store 0xDEADBEEF @0x100, then load word @0x100 → `mem_we_o` at T+1, rsp at T+2; load returns 0xDEADBEEF at T+2.
- Byte store 0xAA @0x101 over 0x11223344 → write 0x1122AA44 at T+2, rsp at T+3; byte load @0x101 returns 0x000000AA.
- Half store @0x103 → `rsp_err_o`=1 at T+1; memory unchanged; no `mem_we_o`. Size 11 behaves the same.
- Both requesters valid continuously → grants alternate 0,1,0,1; each response goes only to the matching `rsp_valid_o` bit.
- Assert `arst_ni` low during RD of a half store → no write occurs, all outputs 0, FSM in IDLE; the next request completes normally.

Source files
------------

// File: rtl/sp_pkg.sv
// ----------------------------------------------------------------------------
// sp_pkg
// Shared types and constants for the data-side memory controller.
//   ADDR_WIDTH / DATA_WIDTH : address and data widths of the 2R/1W memory
//   mem_size_t              : access size encoding carried with each request
//   ctrl_state_t            : controller FSM states
//   size_error()            : illegal size / misalignment detection
// ----------------------------------------------------------------------------
package sp_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      MEM_BYTE    = 2'b00,
      MEM_HALF    = 2'b01,
      MEM_WORD    = 2'b10,
      MEM_ILLEGAL = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RSP
   } ctrl_state_t;

   // An access is illegal when its size code is reserved or when it is not
   // naturally aligned to its own size within the word.
   function automatic logic size_error(mem_size_t size, logic [1:0] offset);
      logic err;
      case (size)
         MEM_BYTE: err = 1'b0;
         MEM_HALF: err = offset[0];
         MEM_WORD: err = (offset != 2'b00);
         default:  err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/sp_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sp_rr_arbiter
// Two-input round-robin arbiter. On contention the requester that was not
// granted last wins; the last-grant pointer only moves when the caller
// reports a completed handshake through 'update'.
//   clk_i   : clock
//   arst_ni : asynchronous active-low reset
//   req     : request vector
//   update  : a grant was consumed this cycle; remember who got it
//   gr      : one-hot grant (combinational from req and pointer)
// ----------------------------------------------------------------------------
module sp_rr_arbiter (
   input  logic       clk_i,
   input  logic       arst_ni,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gr
);

   logic last;

   // Pointer starts at requester 1 so requester 0 wins the first contention.
   always_comb begin
      gr = req;
      if (req == 2'b11) begin
         gr = last ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         last <= 1'b1;
      end else if (update) begin
         last <= gr[1];
      end
   end

endmodule

// File: rtl/sp_mem_ctrl.sv
// ----------------------------------------------------------------------------
// sp_mem_ctrl
// Data-side memory controller sharing read port 1 and the write port of the
// 2R/1W word memory between the LSU (requester 0) and the debug loader
// (requester 1). Sub-word stores become read-modify-write sequences.
//   clk_i, arst_ni          : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o : per-requester request handshake
//   req_we_i, req_addr_i,
//   req_size_i, req_wdata_i : per-requester request payload
//   rsp_valid_o             : one-cycle response pulse to the owner
//   rsp_err_o, rsp_rdata_o  : response error flag and load data
//   mem_raddr_o/mem_rdata_i : read port 1 (combinational read)
//   mem_we_o/mem_waddr_o/
//   mem_wdata_o             : write port (whole aligned words only)
// ----------------------------------------------------------------------------
module sp_mem_ctrl
   import sp_pkg::*;
(
   input  logic                            clk_i,
   input  logic                            arst_ni,
   input  logic [1:0]                      req_valid_i,
   output logic [1:0]                      req_ready_o,
   input  logic [1:0]                      req_we_i,
   input  logic [1:0][ADDR_WIDTH-1:0]      req_addr_i,
   input  logic [1:0][1:0]                 req_size_i,
   input  logic [1:0][DATA_WIDTH-1:0]      req_wdata_i,
   output logic [1:0]                      rsp_valid_o,
   output logic                            rsp_err_o,
   output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
   output logic [ADDR_WIDTH-1:0]           mem_raddr_o,
   input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
   output logic                            mem_we_o,
   output logic [ADDR_WIDTH-1:0]           mem_waddr_o,
   output logic [DATA_WIDTH-1:0]           mem_wdata_o
);

   ctrl_state_t             state_q;
   logic                    id_q;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   mem_size_t               size_q;
   logic [DATA_WIDTH-1:0]   wdata_q;

   logic                    mem_we_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic [1:0]              rsp_valid_q;
   logic                    rsp_err_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;

   logic [1:0]              gr;
   logic                    handshake;
   logic                    sel;
   mem_size_t               sel_size;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic                    sel_err;
   logic [ADDR_WIDTH-1:0]   aligned_addr;

   // Right-aligned, zero-extended view of the addressed lanes of a word.
   function automatic logic [DATA_WIDTH-1:0] extract_lanes(
      logic [DATA_WIDTH-1:0] word, logic [1:0] offset, mem_size_t size);
      logic [DATA_WIDTH-1:0] shifted;
      logic [DATA_WIDTH-1:0] result;
      shifted = word >> {offset, 3'b000};
      case (size)
         MEM_BYTE: result = {24'd0, shifted[7:0]};
         MEM_HALF: result = {16'd0, shifted[15:0]};
         default:  result = word;
      endcase
      return result;
   endfunction

   // Old word with the addressed lanes replaced by right-aligned store data.
   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      logic [DATA_WIDTH-1:0] old_word, logic [DATA_WIDTH-1:0] data,
      logic [1:0] offset, mem_size_t size);
      logic [DATA_WIDTH-1:0] merged;
      merged = old_word;
      case (size)
         MEM_BYTE: merged[{offset, 3'b000} +: 8]       = data[7:0];
         MEM_HALF: merged[{offset[1], 4'b0000} +: 16]  = data[15:0];
         default:  merged = data;
      endcase
      return merged;
   endfunction

   sp_rr_arbiter u_arbiter (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .req     (req_valid_i),
      .update  (handshake),
      .gr      (gr)
   );

   // Ready is forced low during reset so every output reads 0 while arst_ni
   // is asserted, even with requests pending.
   assign req_ready_o  = (arst_ni && (state_q == IDLE)) ? gr : 2'b00;
   assign handshake    = |(req_valid_i & req_ready_o);
   assign sel          = gr[1];
   assign sel_size     = mem_size_t'(req_size_i[sel]);
   assign sel_addr     = req_addr_i[sel];
   assign sel_err      = size_error(sel_size, sel_addr[1:0]);

   assign aligned_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_raddr_o  = aligned_addr;
   assign mem_waddr_o  = aligned_addr;
   assign mem_we_o     = mem_we_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_err_o    = rsp_err_q;
   assign rsp_rdata_o  = rsp_rdata_q;

   // Main FSM. Write strobe and response outputs are registered so they
   // depend on state alone; the async reset clears them at once, which
   // abandons an in-flight read-modify-write before its write is issued.
   // For sub-word stores the word read in RD is merged immediately into the
   // write-data register, which doubles as the captured word.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q     <= IDLE;
         id_q        <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         size_q      <= MEM_BYTE;
         wdata_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 2'b00;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         mem_we_q    <= 1'b0;
         rsp_valid_q <= 2'b00;
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  id_q    <= sel;
                  we_q    <= req_we_i[sel];
                  addr_q  <= sel_addr;
                  size_q  <= sel_size;
                  wdata_q <= req_wdata_i[sel];
                  if (sel_err) begin
                     state_q     <= RSP;
                     rsp_valid_q <= sel ? 2'b10 : 2'b01;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else if (req_we_i[sel] && (sel_size == MEM_WORD)) begin
                     state_q     <= WR;
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= req_wdata_i[sel];
                  end else begin
                     state_q <= RD;
                  end
               end
            end
            RD: begin
               if (we_q) begin
                  state_q     <= WR;
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= merge_lanes(mem_rdata_i, wdata_q, addr_q[1:0], size_q);
               end else begin
                  state_q     <= RSP;
                  rsp_valid_q <= id_q ? 2'b10 : 2'b01;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= extract_lanes(mem_rdata_i, addr_q[1:0], size_q);
               end
            end
            WR: begin
               state_q     <= RSP;
               rsp_valid_q <= id_q ? 2'b10 : 2'b01;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
            default: begin
               state_q     <= IDLE;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sp_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sp_mem_ctrl
// Self-checking bench for sp_mem_ctrl: a 1 KiB word memory model on the
// memory ports, a transaction-level reference memory and arbitration model,
// directed scenarios plus randomized single-requester traffic.
// ----------------------------------------------------------------------------
module tb_sp_mem_ctrl;
   import sp_pkg::*;

   logic                        clk = 1'b0;
   logic                        arstN = 1'b0;
   logic [1:0]                  reqValid = '0;
   logic [1:0]                  reqReady;
   logic [1:0]                  reqWe = '0;
   logic [1:0][ADDR_WIDTH-1:0]  reqAddr = '0;
   logic [1:0][1:0]             reqSize = '0;
   logic [1:0][DATA_WIDTH-1:0]  reqWdata = '0;
   logic [1:0]                  rspValid;
   logic                        rspErr;
   logic [31:0]                 rspRdata;
   logic [31:0]                 memRaddr;
   logic [31:0]                 memRdata;
   logic                        memWe;
   logic [31:0]                 memWaddr;
   logic [31:0]                 memWdata;

   logic [31:0]                 mem    [0:255];
   logic [31:0]                 refMem [0:255];

   int compared = 0;
   int mismatched = 0;
   int lastGrant = 1;

   // Observations of the most recent single transaction.
   bit          hsOk;
   int          wrCount, wrCycle, rspCycle, rspCount;
   logic [31:0] wrAddr, wrData, rdAddr, rspDataS;
   logic [1:0]  rspVec;
   logic        rspErrS;

   sp_mem_ctrl dut (
      .clk_i       (clk),
      .arst_ni     (arstN),
      .req_valid_i (reqValid),
      .req_ready_o (reqReady),
      .req_we_i    (reqWe),
      .req_addr_i  (reqAddr),
      .req_size_i  (reqSize),
      .req_wdata_i (reqWdata),
      .rsp_valid_o (rspValid),
      .rsp_err_o   (rspErr),
      .rsp_rdata_o (rspRdata),
      .mem_raddr_o (memRaddr),
      .mem_rdata_i (memRdata),
      .mem_we_o    (memWe),
      .mem_waddr_o (memWaddr),
      .mem_wdata_o (memWdata)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Read port 1: combinational; an out-of-range or unaligned address
   // returns a poison value so it shows up as a data error.
   assign memRdata = (memRaddr[31:10] == 22'd0 && memRaddr[1:0] == 2'd0) ?
                     mem[memRaddr[9:2]] : 32'hBADBADBA;

   // Memory preload and synchronous write port; a write lands at the edge
   // that ends the WR cycle and is visible from the next cycle on.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      forever begin
         @(posedge clk);
         if (memWe && memWaddr[31:10] == 22'd0 && memWaddr[1:0] == 2'd0)
            mem[memWaddr[9:2]] <= memWdata;
      end
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit refErr(logic [31:0] addr, logic [1:0] size);
      return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00);
   endfunction

   function automatic int refBytes(logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] refLoad(logic [31:0] w, logic [1:0] off, logic [1:0] size);
      logic [31:0] r = 32'd0;
      for (int k = 0; k < refBytes(size); k++)
         r = r | (((w >> (8 * (int'(off) + k))) & 32'hFF) << (8 * k));
      return r;
   endfunction

   function automatic logic [31:0] refStore(logic [31:0] w, logic [1:0] off, logic [1:0] size,
                                            logic [31:0] d);
      logic [31:0] r = w;
      for (int k = 0; k < refBytes(size); k++) begin
         int p = 8 * (int'(off) + k);
         r = (r & ~(32'hFF << p)) | (((d >> (8 * k)) & 32'hFF) << p);
      end
      return r;
   endfunction

   // Issue one request from a single requester starting at a negedge and
   // record what the DUT does over the following five cycles.
   task automatic runTxn(input int id, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata);
      int waitCnt = 0;
      reqValid = 2'b00;
      reqValid[id] = 1'b1;
      reqWe[id] = we;
      reqAddr[id] = addr;
      reqSize[id] = size;
      reqWdata[id] = wdata;
      #1;
      while (!reqReady[id] && waitCnt < 20) begin
         @(negedge clk);
         #1;
         waitCnt++;
      end
      hsOk = reqReady[id];
      if (hsOk) lastGrant = id;
      @(negedge clk);
      reqValid = 2'b00;
      wrCount = 0; wrCycle = 0; rspCycle = 0; rspCount = 0;
      wrAddr = '0; wrData = '0; rspDataS = '0; rspVec = '0; rspErrS = 1'b0;
      rdAddr = memRaddr;
      for (int c = 1; c <= 5; c++) begin
         if (memWe) begin
            wrCount++; wrCycle = c; wrAddr = memWaddr; wrData = memWdata;
         end
         if (rspValid != 2'b00) begin
            rspCount++;
            if (rspCycle == 0) begin
               rspCycle = c; rspVec = rspValid; rspErrS = rspErr; rspDataS = rspRdata;
            end
         end
         if (c < 5) @(negedge clk);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reqValid = 2'b11;
      reqWe = 2'b01;
      reqAddr[0] = 32'h100; reqAddr[1] = 32'h200;
      reqSize[0] = 2'b10;   reqSize[1] = 2'b10;
      #1;
      compared++;
      if ({reqReady, rspValid, rspErr, rspRdata, memRaddr, memWe, memWaddr, memWdata} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: ready=%b rsp=%b err=%b rdata=%h raddr=%h we=%b waddr=%h wdata=%h, all required 0",
                  reqReady, rspValid, rspErr, rspRdata, memRaddr, memWe, memWaddr, memWdata);
      end
      @(negedge clk);
      @(negedge clk);
      arstN = 1'b1;
      #1;
      compared++;
      if (reqReady !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL reset_first_grant: ready=%b required 01", reqReady);
      end
      reqValid = 2'b00;
      lastGrant = 1;
      @(negedge clk);
   endtask

   task automatic test_word_store_load();
      runTxn(0, 1'b1, 32'h100, 2'b10, 32'hDEADBEEF);
      compared++;
      if (!hsOk || wrCount != 1 || wrCycle != 1 || rspCycle != 2 || rspCount != 1) begin
         mismatched++;
         $display("[TB] FAIL word_store_timing: hs=%0d writes=%0d wrcyc=%0d rspcyc=%0d rspcnt=%0d required 1/1/1/2/1",
                  hsOk, wrCount, wrCycle, rspCycle, rspCount);
      end
      compared++;
      if (wrAddr !== 32'h100 || wrData !== 32'hDEADBEEF || rspVec !== 2'b01 || rspErrS !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL word_store_data: waddr=%h wdata=%h rsp=%b err=%b required 100/deadbeef/01/0",
                  wrAddr, wrData, rspVec, rspErrS);
      end
      refMem[8'h40] = 32'hDEADBEEF;
      runTxn(0, 1'b0, 32'h100, 2'b10, 32'h0);
      compared++;
      if (rspCycle != 2 || wrCount != 0 || rspDataS !== 32'hDEADBEEF) begin
         mismatched++;
         $display("[TB] FAIL word_load: rspcyc=%0d writes=%0d rdata=%h required 2/0/deadbeef",
                  rspCycle, wrCount, rspDataS);
      end
   endtask

   task automatic test_byte_store();
      runTxn(0, 1'b1, 32'h100, 2'b10, 32'h11223344);
      refMem[8'h40] = 32'h11223344;
      runTxn(1, 1'b1, 32'h101, 2'b00, 32'hFFFFFFAA);
      compared++;
      if (!hsOk || wrCount != 1 || wrCycle != 2 || rspCycle != 3 || rspVec !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL byte_store_timing: hs=%0d writes=%0d wrcyc=%0d rspcyc=%0d rsp=%b required 1/1/2/3/10",
                  hsOk, wrCount, wrCycle, rspCycle, rspVec);
      end
      compared++;
      if (wrData !== 32'h1122AA44 || rdAddr !== 32'h100) begin
         mismatched++;
         $display("[TB] FAIL byte_store_merge: wdata=%h raddr=%h required 1122aa44/100", wrData, rdAddr);
      end
      refMem[8'h40] = 32'h1122AA44;
      runTxn(0, 1'b0, 32'h101, 2'b00, 32'h0);
      compared++;
      if (rspCycle != 2 || rspDataS !== 32'h000000AA) begin
         mismatched++;
         $display("[TB] FAIL byte_load: rspcyc=%0d rdata=%h required 2/000000aa", rspCycle, rspDataS);
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3] = '{32'h103, 32'h100, 32'h102};
      logic [1:0]  sizes [3] = '{2'b01, 2'b11, 2'b10};
      for (int i = 0; i < 3; i++) begin
         runTxn(i % 2, 1'b1, addrs[i], sizes[i], 32'h5555AAAA);
         compared++;
         if (rspCycle != 1 || rspErrS !== 1'b1 || wrCount != 0 || rspDataS !== 32'h0 ||
             rspVec !== ((i % 2) ? 2'b10 : 2'b01)) begin
            mismatched++;
            $display("[TB] FAIL error_%0d: rspcyc=%0d err=%b writes=%0d rdata=%h rsp=%b required 1/1/0/0",
                     i, rspCycle, rspErrS, wrCount, rspDataS, rspVec);
         end
      end
      runTxn(0, 1'b0, 32'h100, 2'b10, 32'h0);
      compared++;
      if (rspDataS !== 32'h1122AA44 || rspErrS !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL error_mem_unchanged: rdata=%h err=%b required 1122aa44/0", rspDataS, rspErrS);
      end
   endtask

   task automatic test_back_to_back();
      int          grants [$];
      logic [1:0]  rsps   [$];
      logic [31:0] datas  [$];
      int          cyc = 0;
      int          badReady = 0;
      int          first = (lastGrant == 1) ? 0 : 1;
      int          expId;
      reqWe = 2'b10;
      reqAddr[0] = 32'h200; reqSize[0] = 2'b10; reqWdata[0] = 32'h0;
      reqAddr[1] = 32'h205; reqSize[1] = 2'b00; reqWdata[1] = 32'h0000005A;
      reqValid = 2'b11;
      refMem[8'h81] = refStore(refMem[8'h81], 2'd1, 2'b00, 32'h5A);
      while (rsps.size() < 4 && cyc < 60) begin
         #1;
         if (reqReady == 2'b11) badReady++;
         if (reqReady != 2'b00) grants.push_back(reqReady[1] ? 1 : 0);
         if (rspValid != 2'b00) begin
            rsps.push_back(rspValid);
            datas.push_back(rspRdata);
         end
         @(negedge clk);
         cyc++;
      end
      reqValid = 2'b00;
      compared++;
      if (rsps.size() != 4 || badReady != 0) begin
         mismatched++;
         $display("[TB] FAIL b2b_progress: responses=%0d double_ready=%0d required 4/0", rsps.size(), badReady);
      end
      for (int i = 0; i < 4; i++) begin
         expId = (i % 2 == 0) ? first : 1 - first;
         compared++;
         if (i >= grants.size() || grants[i] != expId) begin
            mismatched++;
            $display("[TB] FAIL b2b_grant_%0d: got %0d required %0d", i,
                     (i < grants.size()) ? grants[i] : -1, expId);
         end
         compared++;
         if (i >= rsps.size() || rsps[i] !== (expId ? 2'b10 : 2'b01) ||
             datas[i] !== (expId ? 32'h0 : refMem[8'h80])) begin
            mismatched++;
            $display("[TB] FAIL b2b_rsp_%0d: rsp=%b rdata=%h required owner %0d data %h", i,
                     (i < rsps.size()) ? rsps[i] : 2'bxx, (i < datas.size()) ? datas[i] : 32'hx,
                     expId, expId ? 32'h0 : refMem[8'h80]);
         end
      end
      lastGrant = 1 - first;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_during_rmw();
      reqValid = 2'b01;
      reqWe[0] = 1'b1; reqAddr[0] = 32'h106; reqSize[0] = 2'b01; reqWdata[0] = 32'h0000BEEF;
      #1;
      compared++;
      if (reqReady !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL rmw_handshake: ready=%b required 01", reqReady);
      end
      @(negedge clk);
      reqValid = 2'b00;
      compared++;
      if (memRaddr !== 32'h104 || memWe !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rmw_read_phase: raddr=%h we=%b required 104/0", memRaddr, memWe);
      end
      arstN = 1'b0;
      reqValid = 2'b11;
      #1;
      compared++;
      if ({reqReady, rspValid, rspErr, rspRdata, memRaddr, memWe, memWaddr, memWdata} !== '0) begin
         mismatched++;
         $display("[TB] FAIL rmw_reset_outputs: ready=%b rsp=%b we=%b raddr=%h wdata=%h required all 0",
                  reqReady, rspValid, memWe, memRaddr, memWdata);
      end
      @(negedge clk);
      @(negedge clk);
      arstN = 1'b1;
      reqValid = 2'b00;
      lastGrant = 1;
      compared++;
      if (mem[8'h41] !== refMem[8'h41]) begin
         mismatched++;
         $display("[TB] FAIL rmw_no_write: mem=%h required %h", mem[8'h41], refMem[8'h41]);
      end
      runTxn(1, 1'b0, 32'h106, 2'b01, 32'h0);
      compared++;
      if (!hsOk || rspCycle != 2 || rspVec !== 2'b10 || rspDataS !== refLoad(refMem[8'h41], 2'd2, 2'b01)) begin
         mismatched++;
         $display("[TB] FAIL rmw_after_reset: hs=%0d rspcyc=%0d rsp=%b rdata=%h required 1/2/10/%h",
                  hsOk, rspCycle, rspVec, rspDataS, refLoad(refMem[8'h41], 2'd2, 2'b01));
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int          id    = $urandom_range(0, 1);
         bit          we    = 1'($urandom_range(0, 1));
         logic [31:0] addr  = 32'($urandom_range(0, 1023));
         logic [1:0]  size  = 2'($urandom_range(0, 3));
         logic [31:0] wdata = $urandom;
         bit          e     = refErr(addr, size);
         int          idx   = int'(addr[9:2]);
         bit          expWr = !e && we;
         int          expWrCyc  = (size == 2'b10) ? 1 : 2;
         int          expRspCyc = e ? 1 : (!we ? 2 : ((size == 2'b10) ? 2 : 3));
         logic [31:0] expWord = refStore(refMem[idx], addr[1:0], size, wdata);
         logic [31:0] expData = (!e && !we) ? refLoad(refMem[idx], addr[1:0], size) : 32'h0;
         runTxn(id, we, addr, size, wdata);
         compared++;
         if (!hsOk || rspCycle != expRspCyc || rspCount != 1 || rspVec !== (id ? 2'b10 : 2'b01) || rspErrS !== e) begin
            mismatched++;
            $display("[TB] FAIL rnd_rsp txn %0d: hs=%0d cyc=%0d cnt=%0d rsp=%b err=%b required cyc %0d owner %0d err %0d",
                     n, hsOk, rspCycle, rspCount, rspVec, rspErrS, expRspCyc, id, e);
         end
         compared++;
         if (rspDataS !== expData) begin
            mismatched++;
            $display("[TB] FAIL rnd_rdata txn %0d: got %h required %h", n, rspDataS, expData);
         end
         compared++;
         if (wrCount != (expWr ? 1 : 0)) begin
            mismatched++;
            $display("[TB] FAIL rnd_wrcount txn %0d: got %0d required %0d", n, wrCount, expWr ? 1 : 0);
         end
         if (expWr) begin
            compared++;
            if (wrCycle != expWrCyc || wrAddr !== {addr[31:2], 2'b00} || wrData !== expWord) begin
               mismatched++;
               $display("[TB] FAIL rnd_write txn %0d: cyc=%0d addr=%h data=%h required %0d/%h/%h",
                        n, wrCycle, wrAddr, wrData, expWrCyc, {addr[31:2], 2'b00}, expWord);
            end
            refMem[idx] = expWord;
         end
         if (!e && !(we && size == 2'b10)) begin
            compared++;
            if (rdAddr !== {addr[31:2], 2'b00}) begin
               mismatched++;
               $display("[TB] FAIL rnd_raddr txn %0d: got %h required %h", n, rdAddr, {addr[31:2], 2'b00});
            end
         end
      end
   endtask

   task automatic test_memory_image();
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) bad++;
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("[TB] FAIL memory_image: %0d words differ, required 0", bad);
      end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      #1;
      for (int i = 0; i < 256; i++) refMem[i] = mem[i];
      test_reset();
      test_word_store_load();
      test_byte_store();
      test_errors();
      test_back_to_back();
      test_reset_during_rmw();
      test_random();
      test_memory_image();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
